// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl shared definitions.
// Op codes, bus sizes, FSM states and the bus size decoder.
package mem_access_ctrl_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;

  localparam logic [1:0] DSIZE_BYTE = 2'd0;
  localparam logic [1:0] DSIZE_HALF = 2'd1;
  localparam logic [1:0] DSIZE_WORD = 2'd2;

  typedef enum logic [1:0] {
    MEMS_IDLE = 2'd0,
    MEMS_ADDR = 2'd1,
    MEMS_DATA = 2'd2,
    MEMS_HOLD = 2'd3
  } mems_t;

  // Stores size from their strobes, loads from the op code.
  function automatic logic [1:0] f_size(
    input logic [7:0] op,
    input logic [3:0] wen
  );
    logic [1:0] s;
    s = DSIZE_BYTE;
    if (wen != 4'b0000) begin
      if (wen == 4'b1111)
        s = DSIZE_WORD;
      else if (wen == 4'b1100 || wen == 4'b0011)
        s = DSIZE_HALF;
    end else begin
      if (op == EXE_LW_OP)
        s = DSIZE_WORD;
      else if (op == EXE_LH_OP || op == EXE_LHU_OP)
        s = DSIZE_HALF;
    end
    return s;
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_extend.sv
// load_extend: picks the addressed lane of a read word
// and sign- or zero-extends it for write-back.
module load_extend
  import mem_access_ctrl_pkg::*;
(
  input  logic [7:0]  i_op,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by offset, half by offset bit 1.
  always_comb begin
    w_byte = i_rdata[7:0];
    unique case (i_off)
      2'd0: w_byte = i_rdata[7:0];
      2'd1: w_byte = i_rdata[15:8];
      2'd2: w_byte = i_rdata[23:16];
      2'd3: w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Extension by load type; unknown ops give zero.
  always_comb begin
    o_result = '0;
    unique case (1'b1)
      (i_op == EXE_LB_OP):  o_result = {{24{w_byte[7]}}, w_byte};
      (i_op == EXE_LBU_OP): o_result = {24'd0, w_byte};
      (i_op == EXE_LH_OP):  o_result = {{16{w_half[15]}}, w_half};
      (i_op == EXE_LHU_OP): o_result = {16'd0, w_half};
      (i_op == EXE_LW_OP):  o_result = i_rdata;
      default:              o_result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage data-RAM access on a req/resp bus.
// One access in flight; stalls the pipe until the response.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [7:0]        mem_op,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              flush,
  input  logic              wb_allowin,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata,
  output logic              mem_stall,
  output logic              load_valid,
  output logic [DATA_W-1:0] load_data,
  output logic              addr_err_l,
  output logic              addr_err_s
);

  mems_t             r_state;
  logic [7:0]        r_op;
  logic [1:0]        r_off;
  logic              r_wr;
  logic              r_kill;
  logic [DATA_W-1:0] r_rdata;

  logic              w_is_lw;
  logic              w_is_lh;
  logic              w_is_st;
  logic              w_wr;
  logic              w_mis_l;
  logic              w_mis_s;
  logic              w_start;
  logic              w_req;
  logic              w_idle;
  logic              w_addr;
  logic              w_data;
  logic              w_hold;
  logic [DATA_W-1:0] w_src;

  assign w_idle = (r_state == MEMS_IDLE);
  assign w_addr = (r_state == MEMS_ADDR);
  assign w_data = (r_state == MEMS_DATA);
  assign w_hold = (r_state == MEMS_HOLD);

  assign w_is_lw = (mem_op == EXE_LW_OP);
  assign w_is_lh = (mem_op == EXE_LH_OP)
                 | (mem_op == EXE_LHU_OP);
  assign w_is_st = (mem_op == EXE_SW_OP)
                 | (mem_op == EXE_SH_OP)
                 | (mem_op == EXE_SB_OP);
  assign w_wr    = |mem_wen;

  assign w_mis_l = (w_is_lw & |mem_addr[1:0])
                 | (w_is_lh & mem_addr[0]);
  assign w_mis_s = w_is_st & ~w_wr;

  // Reset gating keeps every status output low while resetn is low.
  assign addr_err_l = resetn & mem_en & w_mis_l;
  assign addr_err_s = resetn & mem_en & w_mis_s;

  assign w_start = resetn & mem_en & ~flush
                 & ~w_mis_l & ~w_mis_s & w_idle;
  assign w_req   = w_start | w_addr;

  assign data_req   = w_req;
  assign data_wr    = w_req & w_wr;
  assign data_size  = w_req ? f_size(mem_op, mem_wen)
                            : DSIZE_BYTE;
  assign data_addr  = mem_addr;
  assign data_wstrb = mem_wen;
  assign data_wdata = mem_wdata;

  assign mem_stall = w_start | w_addr
                   | (w_data & ~(data_data_ok & wb_allowin))
                   | (w_hold & ~wb_allowin);

  assign load_valid = ~r_wr & ~r_kill & wb_allowin
                    & ((w_data & data_data_ok & ~flush)
                       | w_hold);

  // Bypass the bus word on the response cycle so no extra stall is needed.
  assign w_src = w_data ? data_rdata : r_rdata;

  load_extend u_ext (
    .i_op     (r_op),
    .i_off    (r_off),
    .i_rdata  (w_src),
    .o_result (load_data)
  );

  // Access FSM: issue, wait for address, wait for data, hold for WB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= MEMS_IDLE;
      r_op    <= '0;
      r_off   <= '0;
      r_wr    <= 1'b0;
      r_kill  <= 1'b0;
      r_rdata <= '0;
    end else begin
      unique case (r_state)
        MEMS_IDLE: begin
          r_kill <= 1'b0;
          if (w_start) begin
            r_op    <= mem_op;
            r_off   <= mem_addr[1:0];
            r_wr    <= w_wr;
            r_state <= data_addr_ok ? MEMS_DATA : MEMS_ADDR;
          end
        end
        MEMS_ADDR: begin
          if (flush)
            r_kill <= 1'b1;
          if (data_addr_ok)
            r_state <= MEMS_DATA;
        end
        MEMS_DATA: begin
          if (flush)
            r_kill <= 1'b1;
          if (data_data_ok) begin
            r_rdata <= data_rdata;
            if (wb_allowin) begin
              r_state <= MEMS_IDLE;
              r_kill  <= 1'b0;
            end else begin
              r_state <= MEMS_HOLD;
            end
          end
        end
        MEMS_HOLD: begin
          if (wb_allowin) begin
            r_state <= MEMS_IDLE;
            r_kill  <= 1'b0;
          end
        end
        default: r_state <= MEMS_IDLE;
      endcase
    end
  end

endmodule
